tile_xy_route_fifo: RTL

Parametrised per-tile, single-axis mesh hop buffer for cache-line request flits. It replaces the fixed 8-entry, two-lane X/Y FIFO. It accepts flits from the two axis neighbours and from the local tile, forwards flits that are not for this tile, and delivers matching flits to the local tile. Compared with the previous block it adds depth/width parameters, explicit full/empty, registered stop (credit) backpressure, starvation-bounded injection, round-robin local delivery and sticky error flags.

---
 rtl/tile_xy_route_fifo_pkg.sv | 24 ++
 rtl/tile_xy_route_fifo_if.sv | 66 ++++++
 rtl/tile_xy_route_fifo_sync_fifo.sv | 60 ++++++
 rtl/tile_xy_route_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_xy_route_fifo_pkg.sv
// tile_xy_pkg: shared types and helpers for the single-axis mesh hop buffer.
//   flit_t      : one cache-line request flit {tx, ty, payload} at the default widths
//   LANE_BACK   : lane 0, travels toward the lower coordinate
//   LANE_FWD    : lane 1, travels toward the higher coordinate
//   axis_coord  : picks the routing coordinate (X when idx<2, otherwise Y)
package tile_xy_pkg;

  localparam int FLIT_CW = 2;
  localparam int FLIT_PW = 528;  // 66 bytes x 8

  localparam logic LANE_BACK = 1'b0;
  localparam logic LANE_FWD  = 1'b1;

  typedef struct packed {
    logic [FLIT_CW-1:0] tx;
    logic [FLIT_CW-1:0] ty;
    logic [FLIT_PW-1:0] payload;
  } flit_t;

  function automatic int axis_coord(input int idx, input int tx, input int ty);
    return (idx < 2) ? tx : ty;
  endfunction

endpackage

// File: rtl/tile_xy_route_fifo_if.sv
// tile_xy_route_fifo_if: every non-clock signal of the hop buffer.
//   in_*      : local injection (in_valid/in_ready handshake)
//   lnk_in_*  : flits arriving on lane 0 (back) / lane 1 (fwd), lnk_in_stop back to sender
//   lnk_out_* : flits leaving on each lane, peer_stop from the downstream receiver
//   dlv_*     : flits addressed to this tile (dlv_valid/dlv_ready handshake)
//   err_*     : sticky error flags
// Handshake semantics: a transfer happens on a rising clock edge where valid and
// ready are both high. in_ready/dlv_valid may depend combinationally on the
// current inputs; once dlv_valid is high it stays high with dlv_* unchanged until
// dlv_ready is seen. The lane links carry no ready: a flit is valid for exactly
// one cycle, and stop is a registered credit hint that the sender honours one
// cycle late.
// Modports: master = the surrounding tile / mesh, slave = the hop buffer.
interface tile_xy_route_fifo_if #(
  parameter int CW = 2,
  parameter int PW = 528
);
  logic                   in_valid;
  logic                   in_ready;
  logic [CW-1:0]          in_tx;
  logic [CW-1:0]          in_ty;
  logic [PW-1:0]          in_payload;

  logic [1:0]             lnk_in_valid;
  logic [1:0][CW-1:0]     lnk_in_tx;
  logic [1:0][CW-1:0]     lnk_in_ty;
  logic [1:0][PW-1:0]     lnk_in_payload;
  logic [1:0]             lnk_in_stop;

  logic [1:0]             lnk_out_valid;
  logic [1:0][CW-1:0]     lnk_out_tx;
  logic [1:0][CW-1:0]     lnk_out_ty;
  logic [1:0][PW-1:0]     lnk_out_payload;
  logic [1:0]             peer_stop;

  logic                   dlv_valid;
  logic                   dlv_ready;
  logic                   dlv_lane;
  logic [CW-1:0]          dlv_tx;
  logic [CW-1:0]          dlv_ty;
  logic [PW-1:0]          dlv_payload;

  logic                   err_misroute;
  logic                   err_overflow;

  modport master (
    output in_valid, in_tx, in_ty, in_payload,
    output lnk_in_valid, lnk_in_tx, lnk_in_ty, lnk_in_payload,
    output peer_stop, dlv_ready,
    input  in_ready, lnk_in_stop,
    input  lnk_out_valid, lnk_out_tx, lnk_out_ty, lnk_out_payload,
    input  dlv_valid, dlv_lane, dlv_tx, dlv_ty, dlv_payload,
    input  err_misroute, err_overflow
  );

  modport slave (
    input  in_valid, in_tx, in_ty, in_payload,
    input  lnk_in_valid, lnk_in_tx, lnk_in_ty, lnk_in_payload,
    input  peer_stop, dlv_ready,
    output in_ready, lnk_in_stop,
    output lnk_out_valid, lnk_out_tx, lnk_out_ty, lnk_out_payload,
    output dlv_valid, dlv_lane, dlv_tx, dlv_ty, dlv_payload,
    output err_misroute, err_overflow
  );

endinterface

// File: rtl/tile_xy_route_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through head.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   wr_en     : write request; ignored when full unless a read happens the same cycle
//   wr_data   : data written
//   rd_en     : pop the head; ignored when empty
//   rd_data   : current head (meaningless while empty)
//   count     : number of stored entries, 0..DEPTH
//   full/empty: count==DEPTH / count==0
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tile_xy_route_fifo.sv
// tile_xy_route_fifo: per-tile single-axis hop buffer for request flits.
// Flits arriving on a lane either terminate here (delivery FIFO of that lane),
// continue in the lane direction (pass FIFO of that lane) or are dropped as
// misrouted. Each outgoing lane register is fed by its pass FIFO or by a local
// injection, with starvation-bounded priority for the injection. Delivery
// alternates round-robin between the two delivery FIFOs.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : tile_xy_route_fifo_if.slave (injection, lane in/out, delivery, errors)
module tile_xy_route_fifo
  import tile_xy_pkg::*;
#(
  parameter int TILE_X = 0,
  parameter int TILE_Y = 0,
  parameter int IDX    = 0,
  parameter int CW     = FLIT_CW,
  parameter int PW     = FLIT_PW,
  parameter int DEPTH  = 8,
  parameter int STARVE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tile_xy_route_fifo_if.slave  bus
);
  localparam int FW   = 2 * CW + PW;
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int SW   = $clog2(STARVE + 1);
  localparam logic [CW-1:0] OWN = CW'(axis_coord(IDX, TILE_X, TILE_Y));

  // Arrival side
  logic [1:0][FW-1:0]   lnk_in_flit;
  logic [1:0][CW-1:0]   arr_c;
  logic [1:0]           pass_wr;
  logic [1:0]           dlv_wr;
  logic [1:0]           arr_misroute;

  // FIFO status
  logic [1:0][FW-1:0]   pass_head;
  logic [1:0][FW-1:0]   dlv_head;
  logic [1:0][CNTW-1:0] pass_cnt;
  logic [1:0][CNTW-1:0] dlv_cnt;
  logic [1:0]           pass_full;
  logic [1:0]           pass_empty;
  logic [1:0]           dlv_full;
  logic [1:0]           dlv_empty;
  logic [1:0]           pass_rd;
  logic [1:0]           dlv_rd;
  logic [1:0]           pass_ovf;
  logic [1:0]           dlv_ovf;

  // Injection and output arbitration
  logic [CW-1:0]        inj_c;
  logic [FW-1:0]        inj_flit;
  logic                 inj_self;
  logic                 inj_route;
  logic                 inj_dir;
  logic [1:0]           inj_req;
  logic [1:0]           inj_win;
  logic [1:0]           inj_lose;
  logic [1:0][SW-1:0]   starve_q;

  // Registered outputs
  logic [1:0]           out_valid_q;
  logic [1:0][FW-1:0]   out_flit_q;
  logic [1:0]           stop_q;
  logic                 err_misroute_q;
  logic                 err_overflow_q;

  // Delivery selection
  logic                 rr_q;
  logic                 hold_q;
  logic                 hold_lane_q;
  logic                 dlv_any;
  logic                 dlv_sel;
  logic                 dlv_fire;

  // ---------------------------------------------------------------------------
  // Arrival classification: terminate, continue in lane direction, or misroute.
  // ---------------------------------------------------------------------------
  always_comb begin
    lnk_in_flit  = '0;
    arr_c        = '0;
    pass_wr      = '0;
    dlv_wr       = '0;
    arr_misroute = '0;
    for (int d = 0; d < 2; d++) begin
      lnk_in_flit[d] = {bus.lnk_in_tx[d], bus.lnk_in_ty[d], bus.lnk_in_payload[d]};
      arr_c[d]       = CW'(axis_coord(IDX, int'(bus.lnk_in_tx[d]), int'(bus.lnk_in_ty[d])));
      if (bus.lnk_in_valid[d]) begin
        if (arr_c[d] == OWN) begin
          dlv_wr[d] = 1'b1;
        end else if ((d == int'(LANE_FWD)) ? (arr_c[d] > OWN) : (arr_c[d] < OWN)) begin
          pass_wr[d] = 1'b1;
        end else begin
          arr_misroute[d] = 1'b1;
        end
      end
    end
  end

  for (genvar d = 0; d < 2; d++) begin : g_lane
    sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_pass (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (pass_wr[d]),
      .wr_data (lnk_in_flit[d]),
      .rd_en   (pass_rd[d]),
      .rd_data (pass_head[d]),
      .count   (pass_cnt[d]),
      .full    (pass_full[d]),
      .empty   (pass_empty[d])
    );

    sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_dlv (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (dlv_wr[d]),
      .wr_data (lnk_in_flit[d]),
      .rd_en   (dlv_rd[d]),
      .rd_data (dlv_head[d]),
      .count   (dlv_cnt[d]),
      .full    (dlv_full[d]),
      .empty   (dlv_empty[d])
    );
  end

  // ---------------------------------------------------------------------------
  // Injection: lane 1 when the target lies above us, lane 0 when below.
  // A self-addressed injection is accepted and discarded.
  // ---------------------------------------------------------------------------
  assign inj_c     = CW'(axis_coord(IDX, int'(bus.in_tx), int'(bus.in_ty)));
  assign inj_flit  = {bus.in_tx, bus.in_ty, bus.in_payload};
  assign inj_self  = bus.in_valid && (inj_c == OWN);
  assign inj_route = bus.in_valid && (inj_c != OWN);
  assign inj_dir   = (inj_c > OWN);
  assign inj_req   = {inj_route && inj_dir, inj_route && !inj_dir};

  // Pass traffic normally wins; after STARVE consecutive losses the injection
  // takes the lane. A stopped lane issues nothing and nobody loses.
  always_comb begin
    inj_win  = '0;
    inj_lose = '0;
    pass_rd  = '0;
    for (int d = 0; d < 2; d++) begin
      if (!bus.peer_stop[d]) begin
        if (inj_req[d] && (pass_empty[d] || (starve_q[d] >= SW'(STARVE)))) begin
          inj_win[d] = 1'b1;
        end else if (!pass_empty[d]) begin
          pass_rd[d]  = 1'b1;
          inj_lose[d] = inj_req[d];
        end
      end
    end
  end

  assign bus.in_ready = !rst && (inj_self || (|inj_win));

  // Overflow only when the write is actually refused (no read in the same cycle).
  always_comb begin
    pass_ovf = '0;
    dlv_ovf  = '0;
    for (int d = 0; d < 2; d++) begin
      pass_ovf[d] = pass_wr[d] && pass_full[d] && !pass_rd[d];
      dlv_ovf[d]  = dlv_wr[d] && dlv_full[d] && !dlv_rd[d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= '0;
      out_flit_q     <= '0;
      starve_q       <= '0;
      stop_q         <= '0;
      err_misroute_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        out_valid_q[d] <= inj_win[d] || pass_rd[d];
        if (inj_win[d]) begin
          out_flit_q[d] <= inj_flit;
        end else if (pass_rd[d]) begin
          out_flit_q[d] <= pass_head[d];
        end
        if (inj_win[d]) begin
          starve_q[d] <= '0;
        end else if (inj_lose[d]) begin
          starve_q[d] <= starve_q[d] + 1'b1;
        end
        // Two spare entries cover the sender's one-cycle reaction delay.
        stop_q[d] <= (pass_cnt[d] >= CNTW'(DEPTH - 2)) ||
                     (dlv_cnt[d]  >= CNTW'(DEPTH - 2));
      end
      err_misroute_q <= err_misroute_q || (|arr_misroute) || inj_self;
      err_overflow_q <= err_overflow_q || (|pass_ovf) || (|dlv_ovf);
    end
  end

  always_comb begin
    bus.lnk_out_tx      = '0;
    bus.lnk_out_ty      = '0;
    bus.lnk_out_payload = '0;
    for (int d = 0; d < 2; d++) begin
      {bus.lnk_out_tx[d], bus.lnk_out_ty[d], bus.lnk_out_payload[d]} = out_flit_q[d];
    end
  end

  assign bus.lnk_out_valid = out_valid_q;
  assign bus.lnk_in_stop   = stop_q;
  assign bus.err_misroute  = err_misroute_q;
  assign bus.err_overflow  = err_overflow_q;

  // ---------------------------------------------------------------------------
  // Delivery: round-robin between lanes, falling back to the other lane when the
  // preferred one is empty. While an offer is stalled the chosen lane is pinned,
  // so a late arrival on the preferred lane cannot change dlv_* under the consumer.
  // ---------------------------------------------------------------------------
  always_comb begin
    dlv_any = !rst && !(dlv_empty[0] && dlv_empty[1]);
    if (hold_q) begin
      dlv_sel = hold_lane_q;
    end else if (!dlv_empty[rr_q]) begin
      dlv_sel = rr_q;
    end else begin
      dlv_sel = !rr_q;
    end
    dlv_fire        = dlv_any && bus.dlv_ready;
    dlv_rd          = '0;
    dlv_rd[dlv_sel] = dlv_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= 1'b0;
      hold_q      <= 1'b0;
      hold_lane_q <= LANE_BACK;
    end else begin
      if (dlv_fire) rr_q <= !rr_q;
      hold_q      <= dlv_any && !bus.dlv_ready;
      hold_lane_q <= dlv_sel;
    end
  end

  always_comb begin
    bus.dlv_valid = dlv_any;
    bus.dlv_lane  = dlv_any ? dlv_sel : LANE_BACK;
    {bus.dlv_tx, bus.dlv_ty, bus.dlv_payload} = dlv_any ? dlv_head[dlv_sel] : '0;
  end

endmodule
